urng_taus258: RTL and testbench
===============================

// Module: urng_taus258
// PURPOSE
//  Upstream uniform source for the Gaussian noise generator top level: five-component 64-bit
//  combined Tausworthe URNG (L'Ecuyer lfsr258). Presents a 64-bit word on random[63:0] with a
//  one-cycle go pulse, then holds the word until the consumer reports gng_done.
//  Also provides runtime seed loading and a post-seed warm-up phase.
// PARAMETERS
//  SEED1        64'h0123_4567_89AB_CDEF  reset seed, component 1 (k=63,q=1,s=10)
//  SEED2        64'h1111_2222_3333_4444  reset seed, component 2 (k=55,q=24,s=5)
//  SEED3        64'h5555_6666_7777_8888  reset seed, component 3 (k=52,q=3,s=29)
//  SEED4        64'h9999_AAAA_BBBB_CCCC  reset seed, component 4 (k=47,q=5,s=23)
//  SEED5        64'hDDDD_EEEE_FFFF_0001  reset seed, component 5 (k=41,q=3,s=8)
//  WARM_CYCLES  16                        generator steps discarded after reset/seed load (>=1)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   asynchronous, active-low reset
//  enable     in   1   1 = produce words continuously; 0 = stop after current handshake
//  seed_load  in   1   one-cycle strobe: write seed_data into component seed_idx
//  seed_idx   in   3   component select 0..4; 5..7 invalid
//  seed_data  in   64  seed value
//  random     out  64  uniform word to the GNG; stable from go until gng_done sampled
//  go         out  1   one-cycle start pulse to the GNG
//  gng_done   in   1   GNG finished consuming random (level or pulse; sampled in WAIT only)
//  ready      out  1   1 in IDLE (warm-up complete, no transaction open)
//  seed_err   out  1   one-cycle pulse: seed rejected or corrected
// BEHAVIOUR
//  Step (per component, z 64-bit): b = ((z<<q)^z) >> (k-s); z' = ((z & M) << s) ^ b,
//   M = ~(2^(64-k)-1): FFFF..FFFE, ..FE00, ..F000, ..FFFE_0000, ..FF80_0000 for comps 1..5.
//  Output word = z1^z2^z3^z4^z5, registered into random only on entry to ISSUE.
//  Reset (rst=0): z1..z5 <= SEED1..5; random=0, go=0, ready=0, seed_err=0; state WARM, cnt=0.
//  FSM:
//   WARM  : step all components each cycle; cnt++; at cnt==WARM_CYCLES-1 -> IDLE, cnt<=0.
//   IDLE  : ready=1. seed_load -> SEED handling (below). else enable -> ISSUE.
//   ISSUE : random <= combined word, go=1 for exactly this cycle (registered); -> WAIT.
//   WAIT  : go=0, random held. gng_done=1 -> ADV. No timeout; stuck done=0 holds WAIT.
//   ADV   : step all components once; -> ISSUE if enable else IDLE.
//  Throughput: one word per (GNG latency + 3) cycles; go-to-go minimum 3 cycles.
//  Seed load: accepted only in IDLE; component written next cycle, then -> WARM (cnt=0).
//   If seed_data < 2^(64-k) stored value is seed_data | 2^(64-k), seed_err pulses.
//   seed_idx>4, or seed_load outside IDLE: ignored, no state change, seed_err pulses.
//  enable dropped in WAIT: handshake completes, ADV steps, returns IDLE.
//  gng_done high in ISSUE/IDLE/WARM: ignored.
//  Mid-operation reset: immediate abort, go deasserts asynchronously, seeds revert to params.
// STRUCTURE
//  Shared package: per-component K/Q/S constants, masks, minimum-seed thresholds, state enum.
//  Sub-module taus_comp (params K,Q,S): 64-bit register, load port, step enable; 5 instances.
//  Top: FSM, warm-up counter, XOR combine, output register, seed validation.
// TESTING
//  Reset, defaults, enable=1, gng_done 4 cycles after go -> go exactly 1 cycle wide, first
//   random equals C model of lfsr258 after 16 steps, 100 words match model bit-exact.
//  seed_load idx=2 data=64'h10 in IDLE -> z3=64'h1010, seed_err 1 cycle, ready low 17 cycles.
//  seed_load idx=6, and seed_load during WAIT -> no seed change, seed_err pulses, stream continues.
//  gng_done held 0 for 1000 cycles -> random stable, go stays 0, no step; release -> ADV, next go.
//  rst low during WAIT -> go=0, random=0 at once; after release stream restarts at word 1 of run 1.
//  enable cleared 1 cycle after go -> one handshake completes, IDLE, ready=1, no further go.

Source files
------------

// File: rtl/urng_taus258_pkg.sv
// Shared constants for the five-component lfsr258 Tausworthe generator
// and the sequencing state encoding.
package urng_taus258_pkg;

  localparam int unsigned NCOMP = 5;

  localparam int unsigned TAUS_K [NCOMP] = '{63, 55, 52, 47, 41};
  localparam int unsigned TAUS_Q [NCOMP] = '{1, 24, 3, 5, 3};
  localparam int unsigned TAUS_S [NCOMP] = '{10, 5, 29, 23, 8};

  // Smallest legal seed per component, 2^(64-k); lower values degenerate the recurrence.
  localparam logic [63:0] TAUS_MIN [NCOMP] = '{
    64'h0000_0000_0000_0002,
    64'h0000_0000_0000_0200,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0002_0000,
    64'h0000_0000_0080_0000
  };

  typedef enum logic [2:0] {
    ST_WARM,
    ST_IDLE,
    ST_SEED,
    ST_ISSUE,
    ST_WAIT,
    ST_ADV
  } state_t;

  function automatic logic [63:0] taus_mask(input int unsigned k);
    return ~((64'd1 << (64 - k)) - 64'd1);
  endfunction

endpackage

// File: rtl/urng_taus258_comp.sv
// One Tausworthe component: 64-bit state with seed load and single-step advance.
// z_step exposes the next state so the top can combine post-step words.
module taus_comp
  import urng_taus258_pkg::*;
#(
  parameter int unsigned K    = 63,
  parameter int unsigned Q    = 1,
  parameter int unsigned S    = 10,
  parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        step,
  output logic [63:0] z,
  output logic [63:0] z_step
);

  localparam logic [63:0] MASK = taus_mask(K);

  logic [63:0] b;

  assign b      = ((z << Q) ^ z) >> (K - S);
  assign z_step = ((z & MASK) << S) ^ b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z <= SEED;
    end else if (load) begin
      z <= load_data;
    end else if (step) begin
      z <= z_step;
    end
  end

endmodule

// File: rtl/urng_taus258.sv
// Combined lfsr258 uniform source with go/gng_done handshake, warm-up phase
// and runtime seed loading with validation.
module urng_taus258
  import urng_taus258_pkg::*;
#(
  parameter logic [63:0] SEED1       = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED2       = 64'h1111_2222_3333_4444,
  parameter logic [63:0] SEED3       = 64'h5555_6666_7777_8888,
  parameter logic [63:0] SEED4       = 64'h9999_AAAA_BBBB_CCCC,
  parameter logic [63:0] SEED5       = 64'hDDDD_EEEE_FFFF_0001,
  parameter int unsigned WARM_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [2:0]  seed_idx,
  input  logic [63:0] seed_data,
  output logic [63:0] random,
  output logic        go,
  input  logic        gng_done,
  output logic        ready,
  output logic        seed_err
);

  localparam int unsigned CW = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WARM_CYCLES - 1);
  localparam logic [63:0] SEEDS [NCOMP] = '{SEED1, SEED2, SEED3, SEED4, SEED5};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [63:0]     z      [NCOMP];
  logic [63:0]     z_step [NCOMP];
  logic [63:0]     word;
  logic            step_en;
  logic [NCOMP-1:0] load_en;
  logic [2:0]      pend_idx;
  logic [63:0]     pend_data;
  logic            idx_valid;
  logic [63:0]     min_seed;
  logic [63:0]     seed_fixed;
  logic            seed_low;
  logic            seed_err_nxt;

  for (genvar g = 0; g < NCOMP; g++) begin : g_comp
    taus_comp #(
      .K    (TAUS_K[g]),
      .Q    (TAUS_Q[g]),
      .S    (TAUS_S[g]),
      .SEED (SEEDS[g])
    ) u_comp (
      .clk       (clk),
      .rst       (rst),
      .load      (load_en[g]),
      .load_data (pend_data),
      .step      (step_en),
      .z         (z[g]),
      .z_step    (z_step[g])
    );
  end

  always_comb begin
    idx_valid = 1'b0;
    min_seed  = '0;
    for (int unsigned i = 0; i < NCOMP; i++) begin
      if (seed_idx == 3'(i)) begin
        idx_valid = 1'b1;
        min_seed  = TAUS_MIN[i];
      end
    end
  end

  assign seed_low     = idx_valid && (seed_data < min_seed);
  assign seed_fixed   = seed_low ? (seed_data | min_seed) : seed_data;
  assign seed_err_nxt = seed_load && ((state != ST_IDLE) || !idx_valid || seed_low);

  // Leaving ADV the components step on the same edge random is captured,
  // so the combine must see the post-step values.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NCOMP; i++) begin
      word = word ^ ((state == ST_ADV) ? z_step[i] : z[i]);
    end
  end

  always_comb begin
    load_en = '0;
    if (state == ST_SEED) begin
      for (int unsigned i = 0; i < NCOMP; i++) begin
        if (pend_idx == 3'(i)) load_en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    case (state)
      ST_WARM: begin
        step_en = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (seed_load) begin
          if (idx_valid) state_nxt = ST_SEED;
        end else if (enable) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_SEED:  state_nxt = ST_WARM;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (gng_done) state_nxt = ST_ADV;
      end
      ST_ADV: begin
        step_en   = 1'b1;
        state_nxt = enable ? ST_ISSUE : ST_IDLE;
      end
      default: state_nxt = ST_WARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_WARM;
      cnt       <= '0;
      go        <= 1'b0;
      random    <= '0;
      seed_err  <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
    end else begin
      state    <= state_nxt;
      go       <= (state_nxt == ST_ISSUE);
      seed_err <= seed_err_nxt;
      if (state == ST_WARM) begin
        cnt <= (state_nxt == ST_WARM) ? cnt + 1'b1 : '0;
      end
      if (state_nxt == ST_ISSUE) begin
        random <= word;
      end
      if (state == ST_IDLE && state_nxt == ST_SEED) begin
        pend_idx  <= seed_idx;
        pend_data <= seed_fixed;
      end
    end
  end

  assign ready = (state == ST_IDLE);

endmodule

// File: tb/tb_urng_taus258.sv
// Directed/randomised bench for urng_taus258 against a behavioural lfsr258 model.
module tb_urng_taus258;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        seed_load;
  logic [2:0]  seed_idx;
  logic [63:0] seed_data;
  logic [63:0] random;
  logic        go;
  logic        gng_done;
  logic        ready;
  logic        seed_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] mz [5];
  logic [63:0] first_word;
  logic [63:0] w;

  always #5 clk = ~clk;

  urng_taus258 dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_idx  (seed_idx),
    .seed_data (seed_data),
    .random    (random),
    .go        (go),
    .gng_done  (gng_done),
    .ready     (ready),
    .seed_err  (seed_err)
  );

  // L'Ecuyer lfsr258 recurrences written out with literal constants.
  task automatic madvance();
    mz[0] = ((mz[0] & 64'hFFFF_FFFF_FFFF_FFFE) << 10) ^ (((mz[0] << 1)  ^ mz[0]) >> 53);
    mz[1] = ((mz[1] & 64'hFFFF_FFFF_FFFF_FE00) << 5)  ^ (((mz[1] << 24) ^ mz[1]) >> 50);
    mz[2] = ((mz[2] & 64'hFFFF_FFFF_FFFF_F000) << 29) ^ (((mz[2] << 3)  ^ mz[2]) >> 23);
    mz[3] = ((mz[3] & 64'hFFFF_FFFF_FFFE_0000) << 23) ^ (((mz[3] << 5)  ^ mz[3]) >> 24);
    mz[4] = ((mz[4] & 64'hFFFF_FFFF_FF80_0000) << 8)  ^ (((mz[4] << 3)  ^ mz[4]) >> 33);
  endtask

  task automatic mreset();
    mz[0] = 64'h0123_4567_89AB_CDEF;
    mz[1] = 64'h1111_2222_3333_4444;
    mz[2] = 64'h5555_6666_7777_8888;
    mz[3] = 64'h9999_AAAA_BBBB_CCCC;
    mz[4] = 64'hDDDD_EEEE_FFFF_0001;
    repeat (16) madvance();
  endtask

  function automatic logic [63:0] mword();
    return mz[0] ^ mz[1] ^ mz[2] ^ mz[3] ^ mz[4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_go();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (go === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk1("go_arrives", ok, 1'b1);
  endtask

  // One full handshake; gng_done is sampled lat cycles after go rose (lat >= 3 with seed_wait).
  task automatic do_word(input int lat, input bit drop_en, input bit seed_wait,
                         output logic [63:0] obs);
    logic [63:0] held;
    wait_go();
    obs  = random;
    held = random;
    chk64("word", random, mword());
    tick();
    chk1("go_width", go, 1'b0);
    chk64("hold_first", random, held);
    if (drop_en) enable = 1'b0;
    if (seed_wait) begin
      seed_load = 1'b1;
      seed_idx  = 3'd0;
      seed_data = 64'h0000_0000_0000_0005;
    end
    for (int i = 2; i < lat; i++) begin
      tick();
      seed_load = 1'b0;
      chk1("go_low_wait", go, 1'b0);
      chk64("hold_wait", random, held);
      chk1("seed_err_wait", seed_err, seed_wait && i == 2);
    end
    seed_load = 1'b0;
    gng_done  = 1'b1;
    tick();
    gng_done  = 1'b0;
    madvance();
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    enable    = 1'b0;
    seed_load = 1'b0;
    seed_idx  = '0;
    seed_data = '0;
    gng_done  = 1'b0;
    mreset();

    repeat (3) tick();
    chk1("rst_go", go, 1'b0);
    chk64("rst_random", random, 64'd0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_seed_err", seed_err, 1'b0);

    // Warm-up length after reset release; gng_done high must be ignored.
    gng_done = 1'b1;
    rst = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    gng_done = 1'b0;
    chk64("warm_len", 64'(n), 64'd16);
    tick();
    chk1("idle_ready", ready, 1'b1);
    chk1("idle_no_go", go, 1'b0);

    enable = 1'b1;
    do_word(4, 1'b0, 1'b0, first_word);
    for (int k = 1; k < 100; k++) begin
      do_word(int'($urandom_range(2, 6)), 1'b0, 1'b0, w);
    end

    do_word(4, 1'b0, 1'b1, w);
    do_word(1000, 1'b0, 1'b0, w);
    do_word(int'($urandom_range(2, 5)), 1'b0, 1'b0, w);

    do_word(3, 1'b1, 1'b0, w);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk1("drop_ready", ready, 1'b1);
      chk1("drop_no_go", go, 1'b0);
      tick();
    end

    seed_load = 1'b1;
    seed_idx  = 3'd6;
    seed_data = 64'hDEAD_BEEF_0000_0000;
    tick();
    seed_load = 1'b0;
    chk1("bad_idx_err", seed_err, 1'b1);
    chk1("bad_idx_ready", ready, 1'b1);
    tick();
    chk1("bad_idx_err_end", seed_err, 1'b0);
    chk1("bad_idx_ready2", ready, 1'b1);

    seed_load = 1'b1;
    seed_idx  = 3'd2;
    seed_data = 64'h0000_0000_0000_0010;
    tick();
    seed_load = 1'b0;
    chk1("fix_err", seed_err, 1'b1);
    chk1("fix_ready", ready, 1'b0);
    n = 1;
    tick();
    chk1("fix_err_end", seed_err, 1'b0);
    while (!ready && n < 100) begin
      n++;
      tick();
    end
    chk64("seed_busy_len", 64'(n), 64'd17);
    mz[2] = 64'h0000_0000_0000_1010;
    repeat (16) madvance();

    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_word(int'($urandom_range(2, 6)), 1'b0, 1'b0, w);
    end

    wait_go();
    tick();
    rst = 1'b0;
    #1;
    chk1("abort_go", go, 1'b0);
    chk64("abort_random", random, 64'd0);
    chk1("abort_ready", ready, 1'b0);
    tick();
    rst = 1'b1;
    mreset();
    do_word(4, 1'b0, 1'b0, w);
    chk64("restart_first", w, first_word);
    do_word(3, 1'b0, 1'b0, w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
